if_fetch_ctrl: RTL

Sequencer for the instruction-fetch front end. It owns the fetch PC and issues aligned two-instruction fetch requests to the ICache. It discards ICache responses made stale by a flush, and drives the push into the IF1 stage register and fetch buffer. It also serialises ICache cache-ops (CACOP) against normal fetch, so a cache-op never overlaps an in-flight fetch.

---
 rtl/if_fetch_ctrl_pkg.sv | 20 ++
 rtl/if_fetch_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// if_fetch_ctrl_pkg
//   Shared definitions for the instruction-fetch sequencer:
//   reset PC default, cache-op code width and the fetch FSM encodings.
package if_fetch_ctrl_pkg;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h1c00_0000;
   localparam int          CACOP_CODE_W     = 5;

   // RUN   : normal fetch issue
   // DRAIN : fetch blocked, waiting for every in-flight response to return
   // ISSUE : cache-op presented to the ICache
   // WAIT  : cache-op accepted, waiting for completion
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      ISSUE = 2'd2,
      WAIT  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl
//   Instruction-fetch sequencer. Owns the fetch PC, issues aligned
//   FETCH_BYTES requests to the ICache, kills responses made stale by a
//   flush, drives the IF1/fetch-buffer push and serialises ICache cache-ops
//   against normal fetch.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   flush, flush_target       backend redirect pulse and its PC
//   stall, fetch_buf_full     issue gates from the backend / fetch buffer
//   ic_req_valid/ready/pc     fetch request handshake to the ICache
//   ic_resp_valid             ICache response (never back-pressured)
//   ic_resp_kill, fifo_push   response classification (stale / live)
//   cacop_req/code/addr       cache-op request from the backend (level)
//   ic_cacop_valid/ready      cache-op issue handshake to the ICache
//   ic_cacop_complete         cache-op finished pulse from the ICache
//   ic_cacop_code/addr        cache-op operands latched at issue
//   cacop_done                completion pulse to the backend
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] PC_RESET        = PC_RESET_DEFAULT,
   parameter int          MAX_OUTSTANDING = 2,
   parameter int          FETCH_BYTES     = 8
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    flush,
   input  logic [31:0]             flush_target,
   input  logic                    stall,
   input  logic                    fetch_buf_full,
   output logic                    ic_req_valid,
   input  logic                    ic_req_ready,
   output logic [31:0]             ic_req_pc,
   input  logic                    ic_resp_valid,
   output logic                    ic_resp_kill,
   output logic                    fifo_push,
   input  logic                    cacop_req,
   input  logic [CACOP_CODE_W-1:0] cacop_code,
   input  logic [31:0]             cacop_addr,
   output logic                    ic_cacop_valid,
   input  logic                    ic_cacop_ready,
   input  logic                    ic_cacop_complete,
   output logic [CACOP_CODE_W-1:0] ic_cacop_code,
   output logic [31:0]             ic_cacop_addr,
   output logic                    cacop_done
);

   localparam int               CNT_W     = 3;
   localparam logic [CNT_W-1:0] MAX_OUT   = CNT_W'(MAX_OUTSTANDING);
   localparam logic [31:0]      FETCH_INC = 32'(FETCH_BYTES);

   fetch_state_e            state_reg, state_next;
   logic [31:0]             pc_reg, pc_next;
   logic [CNT_W-1:0]        outstanding_reg, outstanding_next;
   logic [CNT_W-1:0]        kill_cnt_reg, kill_cnt_next;
   logic [CACOP_CODE_W-1:0] cacop_code_reg;
   logic [31:0]             cacop_addr_reg;
   logic                    latch_cacop;
   logic                    req_hs;
   logic                    resp_stale;

   assign ic_req_pc     = pc_reg & ~(FETCH_INC - 32'd1);
   assign req_hs        = ic_req_valid & ic_req_ready;
   assign ic_cacop_code = cacop_code_reg;
   assign ic_cacop_addr = cacop_addr_reg;

   // A response is stale if it belongs to a pre-flush request, or if it
   // lands in the flush cycle itself.
   assign resp_stale   = ic_resp_valid & ((kill_cnt_reg != '0) | flush);
   assign ic_resp_kill = resp_stale;
   assign fifo_push    = ic_resp_valid & ~resp_stale;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg       <= RUN;
         pc_reg          <= PC_RESET;
         outstanding_reg <= '0;
         kill_cnt_reg    <= '0;
         cacop_code_reg  <= '0;
         cacop_addr_reg  <= '0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         outstanding_reg <= outstanding_next;
         kill_cnt_reg    <= kill_cnt_next;
         if (latch_cacop) begin
            cacop_code_reg <= cacop_code;
            cacop_addr_reg <= cacop_addr;
         end
      end
   end

   // ---------------- PC and counters ----------------
   always_comb begin
      pc_next          = pc_reg;
      outstanding_next = outstanding_reg + CNT_W'(req_hs) - CNT_W'(ic_resp_valid);
      kill_cnt_next    = kill_cnt_reg;
      if (flush) begin
         pc_next = flush_target;
         // Every request still in flight becomes stale. Responses already
         // marked stale are a subset of outstanding, so the new count is
         // simply what remains outstanding after this cycle's response.
         kill_cnt_next = outstanding_reg - CNT_W'(ic_resp_valid);
      end else begin
         if (req_hs)
            pc_next = ic_req_pc + FETCH_INC;
         if (ic_resp_valid && (kill_cnt_reg != '0))
            kill_cnt_next = kill_cnt_reg - CNT_W'(1);
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next  = state_reg;
      latch_cacop = 1'b0;
      case (state_reg)
         RUN:   if (cacop_req) state_next = DRAIN;
         DRAIN: if ((outstanding_reg == '0) && (kill_cnt_reg == '0)) begin
                   latch_cacop = 1'b1;
                   state_next  = ISSUE;
                end
         // A completion in the acceptance cycle skips WAIT entirely.
         ISSUE: if (ic_cacop_ready) state_next = ic_cacop_complete ? RUN : WAIT;
         WAIT:  if (ic_cacop_complete) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      // rstn is folded in so no request is presented while held in reset.
      ic_req_valid = rstn & (state_reg == RUN) & ~cacop_req & ~flush & ~stall
                     & ~fetch_buf_full & (outstanding_reg < MAX_OUT);
      ic_cacop_valid = (state_reg == ISSUE);
      cacop_done     = ((state_reg == WAIT) & ic_cacop_complete)
                     | ((state_reg == ISSUE) & ic_cacop_ready & ic_cacop_complete);
   end

endmodule
